mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- WIDTH, 16, data and address width.
- IO_ADDR, 16'hFFFF, memory-mapped button register address.
- BURST_LEN, 4, DMA beats per grant (2..8).

Interface
REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on posedge.
- reset, in, 1, asynchronous active-low reset.
- cpu_req, in, 1, CPU access request; held until cpu_gnt.
- cpu_we, in, 1, CPU write enable.
- cpu_addr, in, WIDTH, CPU address.
- cpu_wdata, in, WIDTH, CPU write data.
- cpu_gnt, out, 1, CPU request accepted this cycle.
- cpu_rvalid, out, 1, CPU read data valid.
- cpu_rdata, out, WIDTH, CPU read data.
- dma_req, in, 1, DMA (display) burst request; read-only.
- dma_addr, in, WIDTH, DMA burst base address.
- dma_gnt, out, 1, burst accepted (one-cycle pulse).
- dma_rvalid, out, 1, DMA beat data valid.
- dma_rdata, out, WIDTH, DMA beat data.
- dma_done, out, 1, last beat delivered (one-cycle pulse).
- start, left, right, in, 1 each, raw active-low buttons.
- mem_we_b, out, 1, memory port B write enable.
- mem_addr_b, out, WIDTH, memory port B address.
- mem_data_b, out, WIDTH, memory port B write data.
- mem_q_b, in, WIDTH, memory port B read data (one-cycle synchronous latency).

Function
REQ-003 SHALL implement an FSM with states IDLE, CPU, DMA_BURST; exactly one requester drives port B per cycle.
REQ-004 SHALL, in IDLE or CPU, grant on cpu_req or dma_req; if both are asserted, the grant SHALL alternate, favouring the requester not granted last; the tie-break pointer resets to favour CPU.
REQ-005 SHALL, on a CPU grant, assert cpu_gnt combinationally in that cycle and drive mem_addr_b=cpu_addr, mem_data_b=cpu_wdata, mem_we_b=cpu_we; the state is CPU for one cycle.
REQ-006 SHALL assert cpu_rvalid exactly one cycle after a CPU read grant and never for writes.
REQ-007 SHALL return on cpu_rdata mem_q_b, except for reads of IO_ADDR, which return the button code: 1 if start is low, else 2 if left is low, else 3 if right is low, else 0 (priority start>left>right).
REQ-008 SHALL pass each button through a 2-flop synchronizer reset to 1 (released); the code uses synchronized values.
REQ-009 SHALL drop CPU writes to IO_ADDR: mem_we_b=0, cpu_gnt still asserted.
REQ-010 SHALL, on a DMA grant, pulse dma_gnt, latch dma_addr, and enter DMA_BURST.
REQ-011 SHALL issue beat k (0..BURST_LEN-1) at latched base+k on consecutive cycles, with mem_we_b=0 and address wrapping modulo 2**WIDTH (FFFF -> 0000).
REQ-012 SHALL assert dma_rvalid with dma_rdata=mem_q_b one cycle after each beat; DMA reads of IO_ADDR return raw mem_q_b.
REQ-013 SHALL pulse dma_done together with the last dma_rvalid.
REQ-014 SHALL ignore cpu_req during DMA_BURST (cpu_gnt=0) and return to IDLE after the final beat; an arbitration decision is allowed in the same cycle as the final rvalid.
REQ-015 SHALL drive mem_we_b=0 and hold mem_addr_b at its last value when no grant is active.

Reset
REQ-016 SHALL, while reset is low, force: state IDLE; all gnt/rvalid/done and mem_we_b at 0; mem_addr_b, mem_data_b, cpu_rdata, dma_rdata at 0; beat counter at 0; synchronizers at 1.
REQ-017 SHALL, when reset is asserted mid-burst, abort the burst with no further dma_rvalid or dma_done; after release, the first grant obeys REQ-004 with CPU favoured.

Verification
REQ-018 SHALL be covered by the following directed scenarios:
- CPU write 0x1234 to 0x0010, then read 0x0010 -> mem_we_b=1 in the grant cycle; cpu_rvalid one cycle after the read grant with cpu_rdata=0x1234.
- left held low 3+ cycles, CPU reads 0xFFFF -> cpu_rdata=2; start and left both low -> 1; CPU writes 0xFFFF -> mem_we_b=0.
- DMA burst at 0xFFFE, BURST_LEN=4 -> addresses FFFE, FFFF, 0000, 0001; 4 rvalids; dma_done on the 4th.
- cpu_req and dma_req asserted together, continuously -> grants alternate CPU, DMA burst, CPU, DMA; cpu_gnt never asserted during DMA_BURST.
- reset pulsed low after beat 2 of a burst -> outputs are 0 immediately (asynchronous); no dma_done afterwards.
- idle with no requests -> mem_we_b stays 0 and no rvalid pulses for 20 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates memory port B between a CPU (single read/write) and a display DMA
// (fixed-length read bursts). Also exposes a memory-mapped button register.
module mem_arbiter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] IO_ADDR   = 16'hFFFF,
  parameter int               BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dma_req,
  input  logic [WIDTH-1:0] dma_addr,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             dma_done,
  input  logic             start,
  input  logic             left,
  input  logic             right,
  output logic             mem_we_b,
  output logic [WIDTH-1:0] mem_addr_b,
  output logic [WIDTH-1:0] mem_data_b,
  input  logic [WIDTH-1:0] mem_q_b
);

  localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, CPU, DMA_BURST} state_t;

  state_t           state_q, state_d;
  logic             prefer_dma_q;
  logic [CNT_W-1:0] beat_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] addr_hold_q;
  logic [WIDTH-1:0] data_hold_q;
  logic [2:0]       btn_p0, btn_p1;
  logic             cpu_vld_p1, cpu_io_p1;
  logic             dma_vld_p1, dma_done_p1;
  logic             beat_act, last_beat;
  logic [WIDTH-1:0] beat_addr;

  // Buttons are active-low, packed {start, left, right}; start has priority.
  function automatic logic [1:0] button_code(input logic [2:0] btn);
    if (!btn[2]) return 2'd1;
    if (!btn[1]) return 2'd2;
    if (!btn[0]) return 2'd3;
    return 2'd0;
  endfunction

  // Grants are combinational and gated by reset so nothing is granted while it is held.
  always_comb begin
    state_d   = state_q;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    beat_act  = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      DMA_BURST: begin
        beat_act  = 1'b1;
        last_beat = (beat_q == LAST_BEAT);
        if (last_beat) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        if (reset) begin
          if (cpu_req && (!dma_req || !prefer_dma_q)) begin
            cpu_gnt = 1'b1;
            state_d = CPU;
          end else if (dma_req) begin
            dma_gnt = 1'b1;
            state_d = DMA_BURST;
          end
        end
      end
    endcase
  end

  assign beat_addr  = base_q + WIDTH'(beat_q);
  assign mem_we_b   = cpu_gnt && cpu_we && (cpu_addr != IO_ADDR);
  assign mem_addr_b = cpu_gnt ? cpu_addr : (beat_act ? beat_addr : addr_hold_q);
  assign mem_data_b = cpu_gnt ? cpu_wdata : data_hold_q;

  // Stage p0 -> p1: issue cycle to return cycle (memory has one-cycle read latency)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      prefer_dma_q <= 1'b0;
      beat_q       <= '0;
      base_q       <= '0;
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
      btn_p0       <= '1;
      btn_p1       <= '1;
      cpu_vld_p1   <= 1'b0;
      cpu_io_p1    <= 1'b0;
      dma_vld_p1   <= 1'b0;
      dma_done_p1  <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_p0      <= {start, left, right};
      btn_p1      <= btn_p0;
      addr_hold_q <= mem_addr_b;
      if (cpu_gnt) begin
        prefer_dma_q <= 1'b1;
        data_hold_q  <= cpu_wdata;
      end else if (dma_gnt) begin
        prefer_dma_q <= 1'b0;
        base_q       <= dma_addr;
      end
      if (dma_gnt)       beat_q <= '0;
      else if (beat_act) beat_q <= last_beat ? '0 : beat_q + CNT_W'(1);
      cpu_vld_p1  <= cpu_gnt && !cpu_we;
      cpu_io_p1   <= cpu_gnt && (cpu_addr == IO_ADDR);
      dma_vld_p1  <= beat_act;
      dma_done_p1 <= last_beat;
    end
  end

  assign cpu_rvalid = cpu_vld_p1;
  assign cpu_rdata  = cpu_vld_p1 ? (cpu_io_p1 ? WIDTH'(button_code(btn_p1)) : mem_q_b) : '0;
  assign dma_rvalid = dma_vld_p1;
  assign dma_rdata  = dma_vld_p1 ? mem_q_b : '0;
  assign dma_done   = dma_done_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int          BL = 4;
  localparam logic [15:0] IO = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_gnt, dma_rvalid, dma_done;
  logic [15:0] dma_addr, dma_rdata;
  logic        start, left, right;
  logic        mem_we_b;
  logic [15:0] mem_addr_b, mem_data_b, mem_q_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(16), .IO_ADDR(IO), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .start(start), .left(left), .right(right),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_q_b(mem_q_b)
  );

  // Memory behind port B: unwritten words read back a fixed address pattern.
  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  bit [15:0] env_mem [0:65535];
  bit        env_wr  [0:65535];
  always @(posedge clk) begin
    mem_q_b <= env_wr[mem_addr_b] ? env_mem[mem_addr_b] : pat(mem_addr_b);
    if (mem_we_b) begin
      env_mem[mem_addr_b] <= mem_data_b;
      env_wr[mem_addr_b]  <= 1'b1;
    end
  end

  // Reference model state
  bit [15:0]   ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  int          m_busy = 0;
  logic [15:0] m_next = '0, m_last_addr = '0, m_cpu_data = '0, m_dma_data = '0;
  bit          m_fav_dma = 1'b0, m_cpu_pend = 1'b0, m_dma_pend = 1'b0, m_dma_last = 1'b0;
  bit          e_cg = 1'b0, e_dg = 1'b0;
  logic        s_cpu_gnt, s_dma_gnt, s_we, s_cpu_rvalid, s_dma_rvalid, s_dma_done;
  logic [15:0] s_addr, s_cpu_rdata;
  logic [15:0] exp3 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [15:0] btn_code(input logic s, input logic l, input logic r);
    if (!s) return 16'd1;
    if (!l) return 16'd2;
    if (!r) return 16'd3;
    return 16'd0;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [15:0] e_addr;
    bit          e_we;
    s_cpu_gnt = cpu_gnt; s_dma_gnt = dma_gnt; s_we = mem_we_b; s_addr = mem_addr_b;
    s_cpu_rvalid = cpu_rvalid; s_cpu_rdata = cpu_rdata;
    s_dma_rvalid = dma_rvalid; s_dma_done = dma_done;
    if (!reset) begin
      chk_b("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk_b("rst_dma_gnt", dma_gnt, 1'b0);
      chk_b("rst_mem_we_b", mem_we_b, 1'b0);
      chk_b("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk_b("rst_dma_rvalid", dma_rvalid, 1'b0);
      chk_b("rst_dma_done", dma_done, 1'b0);
      chk_w("rst_mem_addr_b", mem_addr_b, 16'h0);
      chk_w("rst_mem_data_b", mem_data_b, 16'h0);
      chk_w("rst_cpu_rdata", cpu_rdata, 16'h0);
      chk_w("rst_dma_rdata", dma_rdata, 16'h0);
      m_busy = 0; m_fav_dma = 1'b0; m_last_addr = '0;
      m_cpu_pend = 1'b0; m_dma_pend = 1'b0; e_cg = 1'b0; e_dg = 1'b0;
      return;
    end
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (m_busy == 0) begin
      if (cpu_req && (!dma_req || !m_fav_dma)) e_cg = 1'b1;
      else if (dma_req)                        e_dg = 1'b1;
    end
    e_we   = e_cg && cpu_we && (cpu_addr != IO);
    e_addr = e_cg ? cpu_addr : ((m_busy > 0) ? m_next : m_last_addr);
    chk_b("cpu_gnt", cpu_gnt, e_cg);
    chk_b("dma_gnt", dma_gnt, e_dg);
    chk_b("mem_we_b", mem_we_b, e_we);
    chk_w("mem_addr_b", mem_addr_b, e_addr);
    if (e_cg) chk_w("mem_data_b", mem_data_b, cpu_wdata);
    chk_b("cpu_rvalid", cpu_rvalid, m_cpu_pend);
    if (m_cpu_pend) chk_w("cpu_rdata", cpu_rdata, m_cpu_data);
    chk_b("dma_rvalid", dma_rvalid, m_dma_pend);
    if (m_dma_pend) chk_w("dma_rdata", dma_rdata, m_dma_data);
    chk_b("dma_done", dma_done, m_dma_pend && m_dma_last);
    // advance to the next cycle
    m_last_addr = e_addr;
    m_cpu_pend  = e_cg && !cpu_we;
    if (m_cpu_pend) m_cpu_data = (cpu_addr == IO) ? btn_code(start, left, right) : ref_rd(cpu_addr);
    if (e_we) begin
      ref_mem[cpu_addr] = cpu_wdata;
      ref_wr[cpu_addr]  = 1'b1;
    end
    m_dma_pend = (m_busy > 0);
    if (m_busy > 0) begin
      m_dma_data = ref_rd(m_next);
      m_dma_last = (m_busy == 1);
      m_next     = m_next + 16'd1;
      m_busy--;
    end
    if (e_cg) m_fav_dma = 1'b1;
    if (e_dg) begin
      m_fav_dma = 1'b0;
      m_busy    = BL;
      m_next    = dma_addr;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    step();
    cpu_req = 1'b0;
    step();
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return IO;
    if (r <= 4) return 16'($urandom_range(0, 31));
    return 16'($urandom);
  endfunction

  initial begin
    int    n_rv, n_done, n_we;
    string seq;
    // Requests held high during reset must not be granted
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
    dma_req = 1'b1; dma_addr = 16'h0100; start = 1'b1; left = 1'b1; right = 1'b1;
    step(); step();
    cpu_req = 1'b0; dma_req = 1'b0; reset = 1'b1;
    idle(2);

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
    step();
    chk_b("s1_wr_gnt", s_cpu_gnt, 1'b1);
    chk_b("s1_wr_we", s_we, 1'b1);
    cpu_read(16'h0010);
    chk_b("s1_rvalid", s_cpu_rvalid, 1'b1);
    chk_w("s1_rdata", s_cpu_rdata, 16'h1234);

    // Button register
    left = 1'b0; idle(3);
    cpu_read(IO);
    chk_b("s2_rvalid", s_cpu_rvalid, 1'b1);
    chk_w("s2_left", s_cpu_rdata, 16'd2);
    start = 1'b0; idle(3);
    cpu_read(IO);
    chk_w("s2_start_left", s_cpu_rdata, 16'd1);
    start = 1'b1; left = 1'b1; right = 1'b0; idle(3);
    cpu_read(IO);
    chk_w("s2_right", s_cpu_rdata, 16'd3);
    right = 1'b1; idle(3);
    cpu_read(IO);
    chk_w("s2_none", s_cpu_rdata, 16'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = IO; cpu_wdata = 16'hAAAA;
    step();
    chk_b("s2_io_gnt", s_cpu_gnt, 1'b1);
    chk_b("s2_io_we", s_we, 1'b0);
    cpu_req = 1'b0; step();
    chk_b("s2_io_no_rvalid", s_cpu_rvalid, 1'b0);

    // DMA burst wrapping past FFFF
    dma_req = 1'b1; dma_addr = 16'hFFFE;
    step();
    chk_b("s3_gnt", s_dma_gnt, 1'b1);
    dma_req = 1'b0; n_rv = 0; n_done = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_w($sformatf("s3_addr%0d", k), s_addr, exp3[k]);
      chk_b("s3_we", s_we, 1'b0);
      if (s_dma_rvalid) n_rv++;
      if (s_dma_done) n_done++;
    end
    step();
    if (s_dma_rvalid) n_rv++;
    chk_b("s3_done_last", s_dma_done, 1'b1);
    chk_i("s3_early_done", n_done, 0);
    chk_i("s3_rvalids", n_rv, 4);

    // Both requesting continuously
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; dma_req = 1'b1; dma_addr = 16'h0020;
    seq = "";
    for (int c = 0; c < 13; c++) begin
      step();
      if (s_cpu_gnt) seq = {seq, "C"};
      if (s_dma_gnt) seq = {seq, "D"};
    end
    chk_s("s4_grant_order", seq, "CDCDC");
    idle(2);

    // Reset in the middle of a burst
    dma_req = 1'b1; dma_addr = 16'h0100;
    step();
    dma_req = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();
    chk_b("s5_async_rvalid", s_dma_rvalid, 1'b0);
    chk_w("s5_async_addr", s_addr, 16'h0);
    step();
    reset = 1'b1; n_rv = 0; n_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (s_dma_rvalid) n_rv++;
      if (s_dma_done) n_done++;
    end
    chk_i("s5_no_done", n_done, 0);
    chk_i("s5_no_rvalid", n_rv, 0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    step();
    cpu_req = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_addr = 16'h0200;
    step();
    chk_b("s5_first_cpu", s_cpu_gnt, 1'b1);
    chk_b("s5_first_no_dma", s_dma_gnt, 1'b0);
    cpu_req = 1'b0;
    step();
    chk_b("s5_then_dma", s_dma_gnt, 1'b1);
    idle(6);

    // Quiet bus
    n_we = 0; n_rv = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_we) n_we++;
      if (s_cpu_rvalid || s_dma_rvalid) n_rv++;
    end
    chk_i("s6_idle_we", n_we, 0);
    chk_i("s6_idle_rvalid", n_rv, 0);

    // Random traffic
    for (int r = 0; r < 2; r++) begin
      start = 1'($urandom_range(0, 1));
      left  = 1'($urandom_range(0, 1));
      right = 1'($urandom_range(0, 1));
      idle(3);
      for (int c = 0; c < 250; c++) begin
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = pick_addr();
          cpu_wdata = 16'($urandom);
        end
        if (!dma_req && $urandom_range(0, 7) == 0) begin
          dma_req  = 1'b1;
          dma_addr = pick_addr();
        end
        step();
        if (e_cg) cpu_req = 1'b0;
        if (e_dg) dma_req = 1'b0;
      end
      idle(6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
